gpio_pad_ctrl: RTL and testbench

//  Per-pin GPIO control stage sitting directly upstream of the bidirectional 8mA NOE pad cells.

---
 rtl/gpio_pad_ctrl_if.sv | 38 +++
 rtl/gpio_pad_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_ctrl_if.sv
// Register-side bundle of one GPIO bank, between the bank registers and the
// pad control stage.
//   master : bank registers; drive the per-pin controls and clear pulses.
//   slave  : gpio_pad_ctrl; returns the input level, interrupt and conflict state.
// Signals (all WIDTH bits, one per pin, except irq):
//   dout, oe, od_mode    output level, output enable, open-drain select
//   rise_en, fall_en     edge interrupt enables
//   irq_clr              write-1-to-clear pulses for irq_status
//   conflict_clr         write-1-to-clear pulses for conflict
//   din                  debounced input level
//   irq_status           sticky edge-event flags
//   irq                  registered OR of irq_status
//   conflict             sticky bus-conflict flags
interface gpio_pad_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] od_mode;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] conflict_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] irq_status;
  logic             irq;
  logic [WIDTH-1:0] conflict;

  modport master (
    output dout, oe, od_mode, rise_en, fall_en, irq_clr, conflict_clr,
    input  din, irq_status, irq, conflict
  );

  modport slave (
    input  dout, oe, od_mode, rise_en, fall_en, irq_clr, conflict_clr,
    output din, irq_status, irq, conflict
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad control stage for one bank, sitting directly in front of the
// bidirectional NOE pad cells.
//   - Registers each pad's O/NOE from push-pull or open-drain settings.
//   - Synchronises and debounces each pad's I return into din.
//   - Raises sticky rise/fall interrupt flags and a registered bank irq.
//   - Flags bus conflicts: a pin driven for the whole round trip that reads
//     back a level other than the one it drove.
// Ports:
//   HCLK, HRESETn   bank clock, asynchronous active-low reset
//   bus             gpio_pad_ctrl_if.slave register-side bundle
//   pad_o, pad_noe  to pad O / NOE (NOE=1 tristates the pad)
//   pad_i           from pad I, asynchronous
// Parameters: SYNC_STAGES must be 2..4, and 2**CNT_W must exceed DEBOUNCE.

// One pin's worth of pad control. Every pin is independent; the bank only
// shares the init-phase timing and the irq reduction.
module gpio_pad_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 3
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic live,          // debounce/edge/conflict logic active
  input  logic load,          // last init cycle: take s_i straight into din
  input  logic dout,
  input  logic oe,
  input  logic od_mode,
  input  logic rise_en,
  input  logic fall_en,
  input  logic irq_clr,
  input  logic conflict_clr,
  input  logic pad_i,
  output logic din,
  output logic irq_status,
  output logic conflict,
  output logic pad_o,
  output logic pad_noe
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_i;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;
  logic                   din_d;
  logic                   edge_set;
  // o_dly[k]/drv_dly[k] hold pad_o and "driven" from k cycles back.
  logic [SYNC_STAGES:1]   o_dly, drv_dly;
  logic                   drv_window, conf_set;

  assign s_i = sync_q[SYNC_STAGES-1];

  // A new level is accepted on the DEBOUNCE-th consecutive live cycle that
  // differs from din; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (live) begin
      if (s_i == din) begin
        cnt_d = '0;
      end else if (DEBOUNCE == 0 || cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        accept = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign din_d = (load | accept) ? s_i : din;

  // accept implies s_i != din, so s_i alone tells rise from fall.
  assign edge_set = accept & ((s_i & rise_en) | (~s_i & fall_en));

  // s_i now reflects what the pad showed SYNC_STAGES cycles after pad_o was
  // registered SYNC_STAGES cycles ago. Requiring drive across the whole
  // window keeps enable/release transitions from looking like conflicts.
  assign drv_window = ~pad_noe & (&drv_dly);
  assign conf_set   = live & drv_window & (o_dly[SYNC_STAGES] ^ s_i);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      din        <= 1'b0;
      irq_status <= 1'b0;
      conflict   <= 1'b0;
      pad_o      <= 1'b0;
      pad_noe    <= 1'b1;
      o_dly      <= '0;
      drv_dly    <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_i};
      cnt_q      <= cnt_d;
      din        <= din_d;
      irq_status <= edge_set | (irq_status & ~irq_clr);
      conflict   <= conf_set | (conflict & ~conflict_clr);
      // Open-drain only ever drives low; a high request releases the pad.
      pad_o      <= dout & ~od_mode;
      pad_noe    <= ~(oe & ~(od_mode & dout));
      o_dly      <= {o_dly[SYNC_STAGES-1:1], pad_o};
      drv_dly    <= {drv_dly[SYNC_STAGES-1:1], ~pad_noe};
    end
  end
endmodule

module gpio_pad_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  gpio_pad_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]  pad_o,
  output logic [WIDTH-1:0]  pad_noe,
  input  logic [WIDTH-1:0]  pad_i
);
  localparam int INIT_W = $clog2(SYNC_STAGES + 2);

  logic [INIT_W-1:0] init_cnt;
  logic              live, load;
  logic              irq_q;
  logic [WIDTH-1:0]  din_w, irq_status_w, conflict_w;

  // The synchroniser needs SYNC_STAGES cycles to fill after reset; the cycle
  // after that seeds din directly so the pads' resting levels never count
  // as edges. The counter parks at SYNC_STAGES+1 (live) until next reset.
  assign live = (init_cnt == INIT_W'(SYNC_STAGES + 1));
  assign load = (init_cnt == INIT_W'(SYNC_STAGES));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      init_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (!live) init_cnt <= init_cnt + 1'b1;
      irq_q <= |irq_status_w;
    end
  end

  gpio_pad_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .CNT_W       (CNT_W)
  ) u_lane [WIDTH-1:0] (
    .gclk         (HCLK),
    .grst_n       (HRESETn),
    .live         (live),
    .load         (load),
    .dout         (bus.dout),
    .oe           (bus.oe),
    .od_mode      (bus.od_mode),
    .rise_en      (bus.rise_en),
    .fall_en      (bus.fall_en),
    .irq_clr      (bus.irq_clr),
    .conflict_clr (bus.conflict_clr),
    .pad_i        (pad_i),
    .din          (din_w),
    .irq_status   (irq_status_w),
    .conflict     (conflict_w),
    .pad_o        (pad_o),
    .pad_noe      (pad_noe)
  );

  assign bus.din        = din_w;
  assign bus.irq_status = irq_status_w;
  assign bus.conflict   = conflict_w;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus randomized traffic, all
// checked against a history-based reference model of the bank.
module tb_gpio_pad_ctrl;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int NH = 4096;

  logic         HCLK    = 1'b0;
  logic         HRESETn = 1'b0;
  logic [W-1:0] pad_o, pad_noe, pad_i;
  logic [W-1:0] ext   = 8'hA5;   // level the external pulls give a released pad
  logic [W-1:0] frc_m = '0;      // pins overdriven by another device
  logic [W-1:0] frc_v = '0;
  int           n_vec = 0;
  int           n_err = 0;

  gpio_pad_ctrl_if #(.WIDTH(W)) bus ();

  gpio_pad_ctrl #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(3)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .pad_o   (pad_o),
    .pad_noe (pad_noe),
    .pad_i   (pad_i)
  );

  always #5 HCLK = ~HCLK;

  // Pad wire: forced pins win, driven pins show pad_o, released pins the pull.
  assign pad_i = (frc_m & frc_v) | (~frc_m & ((~pad_noe & pad_o) | (pad_noe & ext)));

  // ---------------- reference model ----------------
  // Histories indexed by clock edge k since reset release: pad_i seen at
  // edge k, the synchronised level seen at edge k, whether the rules were
  // live at edge k, and the pad state produced by edge k.
  logic [W-1:0] hpi [NH];
  logic [W-1:0] hsi [NH];
  logic [W-1:0] hpo [NH];
  logic [W-1:0] hpd [NH];
  bit           hlive [NH];
  int           k = 0;
  logic [W-1:0] m_din, m_irqs, m_conf, m_po, m_noe, m_si, m_acc, m_cset;
  logic         m_irq;
  bit           m_ok;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      k = 0;
      m_po = '0; m_noe = '1; m_din = '0; m_irqs = '0; m_irq = 1'b0; m_conf = '0;
    end else begin
      k = k + 1;
      hpi[k] = pad_i;
      m_si = (k > S) ? hpi[k-S] : '0;   // sync chain starts from zero
      hsi[k] = m_si;
      hlive[k] = (k >= S + 2);
      m_irq = |m_irqs;
      m_acc = '0;
      m_cset = '0;
      if (hlive[k]) begin
        for (int n = 0; n < W; n++) begin
          // accept when the last D edges were all live and all disagreed with din
          m_ok = 1'b1;
          for (int j = 0; j < D; j++)
            if (!hlive[k-j] || hsi[k-j][n] == m_din[n]) m_ok = 1'b0;
          m_acc[n] = m_ok;
          // conflict: driven through the round trip and the echo differs
          m_ok = (hpo[k-1-S][n] != m_si[n]);
          for (int j = 1; j <= S + 1; j++)
            if (!hpd[k-j][n]) m_ok = 1'b0;
          m_cset[n] = m_ok;
        end
      end
      m_irqs = (m_irqs & ~bus.irq_clr)
             | (m_acc & ~m_din & m_si & bus.rise_en)
             | (m_acc & m_din & ~m_si & bus.fall_en);
      m_conf = (m_conf & ~bus.conflict_clr) | m_cset;
      m_din  = (k == S + 1) ? m_si : (m_din ^ m_acc);
      m_po   = bus.dout & ~bus.od_mode;
      m_noe  = ~(bus.oe & (~bus.od_mode | ~bus.dout));
      hpo[k] = m_po;
      hpd[k] = ~m_noe;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    bus.dout = 8'hFF; bus.oe = 8'hFF; bus.od_mode = '0;
    bus.rise_en = '0; bus.fall_en = '0; bus.irq_clr = '0; bus.conflict_clr = '0;
    ext = 8'hA5; frc_m = '0;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    n_vec++; if (pad_noe !== 8'hFF) begin n_err++; $display("FAIL rst_noe: got %h want ff", pad_noe); end
    n_vec++; if (pad_o !== 8'h00) begin n_err++; $display("FAIL rst_o: got %h want 00", pad_o); end
    n_vec++; if (bus.din !== 8'h00) begin n_err++; $display("FAIL rst_din: got %h want 00", bus.din); end
    n_vec++; if ({bus.irq_status, bus.conflict, bus.irq} !== 17'h0) begin
      n_err++; $display("FAIL rst_flags: got %h/%h/%b want 0", bus.irq_status, bus.conflict, bus.irq); end
    bus.oe = '0;
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    n_vec++; if (bus.din !== 8'h00) begin n_err++; $display("FAIL init_din2: got %h want 00", bus.din); end
    @(negedge HCLK);
    n_vec++; if (bus.din !== 8'hA5) begin n_err++; $display("FAIL init_din3: got %h want a5", bus.din); end
    n_vec++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL init_irq: got %h want 00", bus.irq_status); end
  endtask

  task automatic test_push_pull;
    bus.oe = 8'h0F; bus.dout = 8'h05; bus.od_mode = '0;
    @(negedge HCLK);
    n_vec++; if (pad_noe !== 8'hF0) begin n_err++; $display("FAIL pp_noe: got %h want f0", pad_noe); end
    n_vec++; if (pad_o !== 8'h05) begin n_err++; $display("FAIL pp_o: got %h want 05", pad_o); end
    repeat (6) begin
      @(negedge HCLK);
      n_vec++; if (bus.conflict !== 8'h00) begin n_err++; $display("FAIL pp_conflict: got %h want 00", bus.conflict); end
      n_vec++; if (bus.din !== m_din) begin n_err++; $display("FAIL pp_din: got %h want %h", bus.din, m_din); end
    end
  endtask

  task automatic test_open_drain;
    bus.od_mode = 8'h01; bus.oe = 8'h01; bus.dout = 8'h00;
    @(negedge HCLK);
    n_vec++; if (pad_noe !== 8'hFE) begin n_err++; $display("FAIL od_low_noe: got %h want fe", pad_noe); end
    n_vec++; if (pad_o[0] !== 1'b0) begin n_err++; $display("FAIL od_low_o: got %b want 0", pad_o[0]); end
    bus.dout = 8'h01;
    @(negedge HCLK);
    n_vec++; if (pad_noe !== 8'hFF) begin n_err++; $display("FAIL od_rel_noe: got %h want ff", pad_noe); end
    n_vec++; if (pad_o[0] !== 1'b0) begin n_err++; $display("FAIL od_rel_o: got %b want 0", pad_o[0]); end
  endtask

  task automatic test_debounce;
    bus.oe = '0; bus.od_mode = '0; bus.dout = '0;
    ext[3] = 1'b0;
    repeat (8) @(negedge HCLK);
    ext[3] = 1'b1;
    repeat (3) @(negedge HCLK);
    ext[3] = 1'b0;
    repeat (8) begin
      @(negedge HCLK);
      n_vec++; if (bus.din[3] !== 1'b0) begin n_err++; $display("FAIL db_glitch: got %b want 0", bus.din[3]); end
    end
    ext[3] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge HCLK);
      n_vec++; if (bus.din[3] !== (i == 6)) begin
        n_err++; $display("FAIL db_accept cyc %0d: got %b want %b", i, bus.din[3], (i == 6)); end
    end
  endtask

  task automatic test_irq;
    ext[3] = 1'b0;
    repeat (8) @(negedge HCLK);
    bus.rise_en = 8'h08;
    ext[3] = 1'b1;
    repeat (5) @(negedge HCLK);
    n_vec++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL irq_early: got %h want 00", bus.irq_status); end
    @(negedge HCLK);
    n_vec++; if (bus.irq_status !== 8'h08) begin n_err++; $display("FAIL irq_set: got %h want 08", bus.irq_status); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_lag: got %b want 0", bus.irq); end
    @(negedge HCLK);
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL irq_out: got %b want 1", bus.irq); end
    ext[3] = 1'b0;
    repeat (8) @(negedge HCLK);
    ext[3] = 1'b1;
    repeat (5) @(negedge HCLK);
    bus.irq_clr = 8'h08;               // lands on the accepting edge
    @(negedge HCLK);
    bus.irq_clr = '0;
    n_vec++; if (bus.irq_status !== 8'h08) begin n_err++; $display("FAIL irq_setwins: got %h want 08", bus.irq_status); end
    bus.irq_clr = 8'h08;
    @(negedge HCLK);
    bus.irq_clr = '0;
    n_vec++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL irq_clr: got %h want 00", bus.irq_status); end
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL irq_clr_lag: got %b want 1", bus.irq); end
    @(negedge HCLK);
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b want 0", bus.irq); end
    bus.rise_en = '0;
    bus.fall_en = 8'h08;               // past falls must not show up now
    repeat (3) @(negedge HCLK);
    n_vec++; if (bus.irq_status !== 8'h00) begin n_err++; $display("FAIL irq_retro: got %h want 00", bus.irq_status); end
    bus.fall_en = '0;
  endtask

  task automatic test_conflict;
    int got;
    got = 0;
    bus.oe = 8'h04; bus.dout = 8'h04; bus.od_mode = '0;
    frc_m = 8'h04; frc_v = 8'h00;
    for (int i = 1; i <= 6 && got == 0; i++) begin
      @(negedge HCLK);
      if (bus.conflict[2]) got = i;
    end
    n_vec++; if (got == 0 || got > 4) begin n_err++; $display("FAIL cf_set: got cycle %0d want 1..4", got); end
    n_vec++; if (bus.conflict !== m_conf) begin n_err++; $display("FAIL cf_model: got %h want %h", bus.conflict, m_conf); end
    bus.conflict_clr = 8'h04;
    @(negedge HCLK);
    bus.conflict_clr = '0;
    n_vec++; if (bus.conflict[2] !== 1'b1) begin n_err++; $display("FAIL cf_setwins: got %b want 1", bus.conflict[2]); end
    frc_m = '0;
    repeat (4) @(negedge HCLK);
    bus.conflict_clr = 8'h04;
    @(negedge HCLK);
    bus.conflict_clr = '0;
    n_vec++; if (bus.conflict[2] !== 1'b0) begin n_err++; $display("FAIL cf_clr: got %b want 0", bus.conflict[2]); end
  endtask

  task automatic test_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge HCLK);
      n_vec++; if (bus.din !== m_din) begin n_err++; $display("FAIL rnd_din cyc %0d: got %h want %h", c, bus.din, m_din); end
      n_vec++; if (bus.irq_status !== m_irqs) begin n_err++; $display("FAIL rnd_irqs cyc %0d: got %h want %h", c, bus.irq_status, m_irqs); end
      n_vec++; if (bus.irq !== m_irq) begin n_err++; $display("FAIL rnd_irq cyc %0d: got %b want %b", c, bus.irq, m_irq); end
      n_vec++; if (bus.conflict !== m_conf) begin n_err++; $display("FAIL rnd_conf cyc %0d: got %h want %h", c, bus.conflict, m_conf); end
      n_vec++; if (pad_o !== m_po) begin n_err++; $display("FAIL rnd_o cyc %0d: got %h want %h", c, pad_o, m_po); end
      n_vec++; if (pad_noe !== m_noe) begin n_err++; $display("FAIL rnd_noe cyc %0d: got %h want %h", c, pad_noe, m_noe); end
      if ($urandom_range(0, 15) == 0) bus.oe = 8'($urandom);
      if ($urandom_range(0, 3) == 0)  bus.dout = 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.od_mode = 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        bus.rise_en = 8'($urandom);
        bus.fall_en = 8'($urandom);
      end
      bus.irq_clr      = 8'($urandom & $urandom & $urandom);
      bus.conflict_clr = 8'($urandom & $urandom & $urandom);
      ext = ext ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) begin
        frc_m = 8'($urandom & $urandom);
        frc_v = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.oe = 8'hFF; bus.od_mode = '0; bus.dout = 8'h3C; frc_m = '0;
    bus.irq_clr = '0; bus.conflict_clr = '0;
    repeat (6) @(negedge HCLK);
    @(posedge HCLK);
    #3 HRESETn = 1'b0;
    #1;
    n_vec++; if (pad_noe !== 8'hFF) begin n_err++; $display("FAIL mid_noe: got %h want ff", pad_noe); end
    n_vec++; if (pad_o !== 8'h00) begin n_err++; $display("FAIL mid_o: got %h want 00", pad_o); end
    n_vec++; if ({bus.din, bus.irq_status, bus.conflict, bus.irq} !== 25'h0) begin
      n_err++; $display("FAIL mid_state: got %h/%h/%h/%b want 0", bus.din, bus.irq_status, bus.conflict, bus.irq); end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    n_vec++; if (bus.din !== ext) begin n_err++; $display("FAIL mid_init: got %h want %h", bus.din, ext); end
    test_random(60);
  endtask

  initial begin
    test_reset();
    test_push_pull();
    test_open_drain();
    test_debounce();
    test_irq();
    test_conflict();
    test_random(400);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
